// File: rtl/txiod_pkg.sv
// txiod_pkg: shared state encoding, PRBS7 constants and word bit-reversal for the TX IOD training generator.
package txiod_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_TRAIN, ST_WAIT, ST_DATA} state_t;
  localparam logic [6:0] PRBS7_POLY = 7'h60;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  function automatic logic [7:0] rev8(input logic [7:0] x);
    return {<<{x}};
  endfunction
endpackage

// File: rtl/txiod_prbs7_gen.sv
// txiod_prbs7_gen: PRBS7 (x^7+x^6+1) source advancing 8 steps per enabled cycle; bit i of prbs_o is the i-th generated bit.
module txiod_prbs7_gen
  import txiod_pkg::*;
(
  input  logic       SCLK,
  input  logic       RESET,
  input  logic       en,
  input  logic       load,
  output logic [7:0] prbs_o
);
  logic [6:0] lfsr_q, lfsr_d, s;
  always_comb begin
    s = lfsr_q;
    prbs_o = '0;
    for (int i = 0; i < 8; i++) begin
      prbs_o[i] = ^(s & PRBS7_POLY);
      s = {s[5:0], prbs_o[i]};
    end
    lfsr_d = load ? PRBS7_SEED : en ? s : lfsr_q;
  end
  always_ff @(posedge SCLK) begin
    if (RESET) lfsr_q <= PRBS7_SEED;
    else lfsr_q <= lfsr_d;
  end
endmodule

// File: rtl/txiod_train_gen.sv
// txiod_train_gen: TX IOD word generator (training pattern until far-end alignment, then payload), outputs bit-reversed.
// Optional PRBS7 payload source enabled by defining TXIOD_PRBS7_EN.
module txiod_train_gen
  import txiod_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = 8'hF0,
  parameter logic [7:0] IDLE_PATTERN  = 8'h00,
  parameter int         TRAIN_WORDS   = 256,
  parameter int         ALIGN_TIMEOUT = 4096
) (
  input  logic       SCLK,
  input  logic       RESET,
  input  logic       TRAIN_REQ,
  input  logic       ALIGN_DONE,
  input  logic [7:0] TX_DATA_IN,
  input  logic       TX_VALID,
`ifdef TXIOD_PRBS7_EN
  input  logic       PRBS_MODE,
`endif
  output logic       TX_READY,
  output logic [7:0] TXD,
  output logic       TRAINING,
  output logic       ALIGN_FAIL
);
  localparam int TW_W = TRAIN_WORDS > 1 ? $clog2(TRAIN_WORDS) : 1;
  localparam int AT_W = ALIGN_TIMEOUT > 1 ? $clog2(ALIGN_TIMEOUT) : 1;
  state_t state_q, state_d;
  logic [TW_W-1:0] wcnt_q, wcnt_d;
  logic [AT_W-1:0] tcnt_q, tcnt_d;
  logic [7:0] txd_q, txd_d, prbs_word;
  logic training_q, training_d, fail_q, fail_d, prbs_on;
`ifdef TXIOD_PRBS7_EN
  assign prbs_on = state_q == ST_DATA && PRBS_MODE && !TRAIN_REQ;
  // LFSR is held at its seed outside DATA, so every DATA entry restarts the sequence.
  txiod_prbs7_gen u_prbs (
    .SCLK  (SCLK),
    .RESET (RESET),
    .en    (prbs_on),
    .load  (state_q != ST_DATA),
    .prbs_o(prbs_word)
  );
`else
  assign prbs_on = 1'b0;
  assign prbs_word = 8'h00;
`endif
  assign TX_READY = state_q == ST_DATA && !TRAIN_REQ && !prbs_on;
  assign TXD = txd_q;
  assign TRAINING = training_q;
  assign ALIGN_FAIL = fail_q;
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    tcnt_d = tcnt_q;
    txd_d = rev8(IDLE_PATTERN);
    training_d = 1'b0;
    fail_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_TRAIN;
        wcnt_d = '0;
      end
      ST_TRAIN: begin
        txd_d = rev8(TRAIN_PATTERN);
        training_d = 1'b1;
        if (wcnt_q == TW_W'(TRAIN_WORDS - 1)) begin
          state_d = ST_WAIT;
          tcnt_d = '0;
        end else wcnt_d = wcnt_q + TW_W'(1);
      end
      ST_WAIT: begin
        txd_d = rev8(TRAIN_PATTERN);
        training_d = 1'b1;
        if (ALIGN_DONE) state_d = ST_DATA;
        else if (tcnt_q == AT_W'(ALIGN_TIMEOUT - 1)) begin
          state_d = ST_TRAIN;
          wcnt_d = '0;
          tcnt_d = '0;
          fail_d = 1'b1;
        end else tcnt_d = tcnt_q + AT_W'(1);
      end
      ST_DATA: begin
        // Retrain request drops any offered word and starts the pattern on the very next output.
        if (TRAIN_REQ) begin
          state_d = ST_TRAIN;
          wcnt_d = '0;
          txd_d = rev8(TRAIN_PATTERN);
          training_d = 1'b1;
        end else txd_d = prbs_on ? rev8(prbs_word) : TX_VALID ? rev8(TX_DATA_IN) : rev8(IDLE_PATTERN);
      end
    endcase
  end
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      wcnt_q <= '0;
      tcnt_q <= '0;
      txd_q <= 8'h00;
      training_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      tcnt_q <= tcnt_d;
      txd_q <= txd_d;
      training_q <= training_d;
      fail_q <= fail_d;
    end
  end
endmodule

// File: tb/tb_txiod_train_gen.sv
// tb_txiod_train_gen: directed plan plus randomized traffic checked against a cycle-level behavioural model.
module tb_txiod_train_gen;
  localparam int TW = 4;
  localparam int AT = 8;
`ifdef TXIOD_PRBS7_EN
  localparam bit PRBS_EN = 1'b1;
`else
  localparam bit PRBS_EN = 1'b0;
`endif
  logic SCLK = 1'b0;
  logic RESET, TRAIN_REQ, ALIGN_DONE, TX_VALID, PRBS_MODE;
  logic [7:0] TX_DATA_IN;
  logic TX_READY, TRAINING, ALIGN_FAIL;
  logic [7:0] TXD;
  int n_tests = 0;
  int n_fail = 0;
  int fails_seen;
  int ph = 0;
  int cnt = 0;
  int lfsr = 7'h7F;
  bit m_known = 1'b0;
  logic [7:0] m_txd = 8'h00;
  bit m_trn = 1'b0;
  bit m_fail = 1'b0;

  always #5 SCLK = ~SCLK;

  txiod_train_gen #(.TRAIN_PATTERN(8'hF0), .IDLE_PATTERN(8'h00), .TRAIN_WORDS(TW), .ALIGN_TIMEOUT(AT)) dut (
    .SCLK      (SCLK),
    .RESET     (RESET),
    .TRAIN_REQ (TRAIN_REQ),
    .ALIGN_DONE(ALIGN_DONE),
    .TX_DATA_IN(TX_DATA_IN),
    .TX_VALID  (TX_VALID),
`ifdef TXIOD_PRBS7_EN
    .PRBS_MODE (PRBS_MODE),
`endif
    .TX_READY  (TX_READY),
    .TXD       (TXD),
    .TRAINING  (TRAINING),
    .ALIGN_FAIL(ALIGN_FAIL)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] flip(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = x[i];
    return r;
  endfunction

  function automatic logic [7:0] prbs_chunk(inout int s);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      c[i] = ((s >> 6) ^ (s >> 5)) & 1;
      s = ((s << 1) | c[i]) & 'h7F;
    end
    return c;
  endfunction

  // Modes: 0 idle, 1 training, 2 waiting for alignment, 3 payload.
  task automatic model_step(input bit rst, input bit treq, input bit ad, input bit v, input logic [7:0] d);
    m_fail = 1'b0;
    if (rst) begin
      ph = 0; cnt = 0; m_txd = 8'h00; m_trn = 0; lfsr = 'h7F; m_known = 1;
    end else if (ph == 0) begin
      m_txd = 8'h00; m_trn = 0; ph = 1; cnt = 0;
    end else if (ph == 1) begin
      m_txd = flip(8'hF0); m_trn = 1;
      if (cnt == TW - 1) begin ph = 2; cnt = 0; end else cnt++;
    end else if (ph == 2) begin
      m_txd = flip(8'hF0); m_trn = 1;
      if (ad) begin ph = 3; lfsr = 'h7F; end
      else if (cnt == AT - 1) begin ph = 1; cnt = 0; m_fail = 1; end
      else cnt++;
    end else begin
      if (treq) begin m_txd = flip(8'hF0); m_trn = 1; ph = 1; cnt = 0; end
      else begin
        m_trn = 0;
        if (PRBS_EN && PRBS_MODE) m_txd = flip(prbs_chunk(lfsr));
        else m_txd = v ? flip(d) : 8'h00;
      end
    end
  endtask

  task automatic step(input bit rst, input bit treq, input bit ad, input bit v, input logic [7:0] d);
    RESET = rst; TRAIN_REQ = treq; ALIGN_DONE = ad; TX_VALID = v; TX_DATA_IN = d;
    #1;
    if (m_known) chk("ready", TX_READY, ph == 3 && !treq && !(PRBS_EN && PRBS_MODE));
    @(posedge SCLK);
    model_step(rst, treq, ad, v, d);
    #1;
    chk("txd", TXD, m_txd);
    chk("training", TRAINING, m_trn);
    chk("align_fail", ALIGN_FAIL, m_fail);
  endtask

  initial begin
    logic [7:0] exp_boot [7];
    logic [7:0] pay [3];
    exp_boot = '{8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h00};
    pay = '{8'h01, 8'hA5, 8'h3C};
    PRBS_MODE = 1'b0;
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    chk("reset_txd", TXD, 8'h00);
    chk("reset_training", TRAINING, 0);
    chk("reset_ready", TX_READY, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 0, 8'h00);
      chk($sformatf("boot_txd%0d", i), TXD, exp_boot[i]);
      chk($sformatf("boot_trn%0d", i), TRAINING, i >= 1 && i <= 5);
    end
    chk("data_ready", TX_READY, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, pay[i]);
      chk($sformatf("payload%0d", i), TXD, flip(pay[i]));
    end
    step(0, 1, 1, 1, 8'h55);
    chk("treq_txd", TXD, 8'h0F);
    fails_seen = 0;
    for (int i = 0; i < 13; i++) begin
      step(0, 0, 0, 0, 8'h00);
      fails_seen += int'(ALIGN_FAIL);
      if (i == 11) chk("timeout_pulse", ALIGN_FAIL, 1);
    end
    chk("timeout_once", fails_seen, 1);
    step(1, 0, 0, 0, 8'h00);
    chk("reset_mid_train", TXD, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      PRBS_MODE = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/txiod_train_gen.md
# txiod_train_gen

Transmit-side companion to the receive IOD bit aligner. Generates the 8-bit parallel words fed to a PolarFire TX IOD lane: a training pattern until the far-end receiver reports alignment, then user payload with valid/ready flow control. Every word leaves bit-reversed (logical bit i drives TXD[7-i]), matching the receive path's reversal. Sits between the video/payload source and the TX IOD gearbox in the SCLK domain.

## Interface
Parameters:
- TRAIN_PATTERN, 8'hF0, training word in logical bit order
- IDLE_PATTERN, 8'h00, word sent in DATA when no payload is accepted
- TRAIN_WORDS, 256, minimum training words before alignment is considered (≥1)
- ALIGN_TIMEOUT, 4096, WAIT_ALIGN cycles before declaring failure (≥1)

Ports:
- SCLK  in  1  single clock; all logic rising-edge
- RESET  in  1  synchronous, active-high
- TRAIN_REQ  in  1  level; far end requests retraining
- ALIGN_DONE  in  1  level; far-end receiver bit alignment complete
- TX_DATA_IN  in  8  payload word, logical bit order
- TX_VALID  in  1  payload valid
- TX_READY  out  1  block accepts payload this cycle
- TXD  out  8  registered, bit-reversed word to TX IOD
- TRAINING  out  1  high in TRAIN and WAIT_ALIGN
- ALIGN_FAIL  out  1  one-cycle pulse on WAIT_ALIGN timeout

## Operation
- States: IDLE, TRAIN, WAIT_ALIGN, DATA. Reset → IDLE.
- IDLE: TXD=rev(IDLE_PATTERN); unconditionally → TRAIN next cycle.
- TRAIN: TXD=rev(TRAIN_PATTERN); word counter counts 0..TRAIN_WORDS-1; on final count → WAIT_ALIGN. TRAIN_REQ ignored (already training).
- WAIT_ALIGN: keeps sending pattern; timeout counter increments each cycle. ALIGN_DONE=1 → DATA. Counter reaching ALIGN_TIMEOUT-1 with ALIGN_DONE=0 → TRAIN, counters cleared, ALIGN_FAIL pulses. ALIGN_DONE wins if both occur in the same cycle.
- DATA: TX_READY = (state==DATA) & ~TRAIN_REQ, combinational from state and input. Transfer when TX_VALID & TX_READY: TXD ← rev(TX_DATA_IN). Otherwise TXD ← rev(IDLE_PATTERN). TRAIN_REQ=1 → TRAIN next cycle, no word accepted that cycle.
- Counter widths $clog2 of parameter; no wrap in normal flow (cleared on each state entry).
- Reset mid-operation: any state → IDLE next edge; in-flight word discarded, no partial output.

## Timing
- Reset values: TXD=8'h00, TX_READY=0, TRAINING=0, ALIGN_FAIL=0, counters 0.
- Payload latency: 1 cycle, accept edge to TXD.
- First training word on TXD 2 cycles after RESET deasserts (IDLE cycle, then registered output).
- TRAINING registered, asserts with first training word, deasserts with first DATA-state word.
- Back-to-back throughput: one word per cycle while TX_READY high.

## Configuration
- TXIOD_PRBS7_EN defined: adds input PRBS_MODE (1 bit). In DATA with PRBS_MODE=1, TX_READY=0 and TXD carries successive 8-bit PRBS7 (x^7+x^6+1) chunks, 8 steps per cycle, LFSR seeded 7'h7F at reset and on DATA entry; TRAIN_REQ still takes priority.
- Undefined: no PRBS_MODE port, no LFSR logic; DATA behaviour as above only.

## Structure
- Package txiod_pkg: state enum, PRBS7 polynomial/seed constants, rev8 function.
- Sub-module txiod_prbs7_gen (only instantiated under TXIOD_PRBS7_EN): enable, load, 8-bit parallel output.

## Test plan
- Reset release, TRAIN_WORDS=4, ALIGN_DONE=1 → TXD 00, then 0F ×4, one WAIT_ALIGN word 0F, then DATA; TRAINING high exactly for those 5 words.
- DATA, TX_VALID with 8'h01, 8'hA5, 8'h3C back-to-back → TXD 80, A5, 3C on consecutive cycles, one cycle after each accept.
- DATA, TX_VALID=0 → TXD=00 continuously; TX_READY=1.
- ALIGN_DONE held 0, ALIGN_TIMEOUT=8 → ALIGN_FAIL one pulse after 8 WAIT_ALIGN cycles, training restarts with counter at 0.
- TRAIN_REQ asserted with TX_VALID=1 in DATA → TX_READY=0 that cycle, word not sent, TXD=0F next cycle; RESET asserted mid-TRAIN → TXD=00 next cycle.
- With TXIOD_PRBS7_EN, PRBS_MODE=1 in DATA → TX_READY=0, TXD sequence matches reference PRBS7 model from seed 7F.
